// File: rtl/sample_sequencer_pkg.sv
// Shared definitions for the sample sequencer.
// FSM state encoding and default timing constants.
package sample_sequencer_pkg;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_START = 3'd1,
      ST_WAIT  = 3'd2,
      ST_LOAD  = 3'd3,
      ST_ERR   = 3'd4
   } state_t;

   localparam int DEF_PERIOD_CYC  = 1000000;
   localparam int DEF_TIMEOUT_CYC = 1000;

   localparam int PER_W = 20;
   localparam int TMO_W = 16;

endpackage

// File: rtl/tick_counter.sv
// Modulo-MODULUS counter with enable; held at zero while disabled.
// Ports: clk, rst (async high), en, tc (terminal count while enabled).
module tick_counter #(
   parameter int MODULUS = 16,
   parameter int WIDTH   = 20
) (
   input  logic clk,
   input  logic rst,
   input  logic en,
   output logic tc
);

   localparam logic [WIDTH-1:0] LAST = WIDTH'(MODULUS - 1);

   logic [WIDTH-1:0] cnt;

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         cnt <= '0;
      else if (!en)
         cnt <= '0;
      else if (cnt == LAST)
         cnt <= '0;
      else
         cnt <= cnt + WIDTH'(1);
   end

   assign tc = en && (cnt == LAST);

endmodule

// File: rtl/sample_sequencer.sv
// Periodic ADC conversion sequencer with timeout and sticky error flags.
// Ports: Clk_S, Reset_S, Run_S, Clear_S, Adc_Done in; Adc_Start, Load_R,
//   Temp_Valid, Busy, Timeout_Err, Overrun out (all from registers).
module sample_sequencer
   import sample_sequencer_pkg::*;
#(
   parameter int PERIOD_CYC  = DEF_PERIOD_CYC,
   parameter int TIMEOUT_CYC = DEF_TIMEOUT_CYC
) (
   input  logic Clk_S,
   input  logic Reset_S,
   input  logic Run_S,
   input  logic Clear_S,
   input  logic Adc_Done,
   output logic Adc_Start,
   output logic Load_R,
   output logic Temp_Valid,
   output logic Busy,
   output logic Timeout_Err,
   output logic Overrun
);

   localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYC - 1);

   state_t           state;
   logic [TMO_W-1:0] tmo_cnt;
   logic             tick;

   tick_counter #(
      .MODULUS (PERIOD_CYC),
      .WIDTH   (PER_W)
   ) u_per (
      .clk (Clk_S),
      .rst (Reset_S),
      .en  (Run_S),
      .tc  (tick)
   );

   always_ff @(posedge Clk_S or posedge Reset_S) begin
      if (Reset_S) begin
         state       <= ST_IDLE;
         tmo_cnt     <= '0;
         Temp_Valid  <= 1'b0;
         Timeout_Err <= 1'b0;
         Overrun     <= 1'b0;
      end else begin
         // clear first so a set event in the same cycle wins
         if (Clear_S) begin
            Timeout_Err <= 1'b0;
            Overrun     <= 1'b0;
         end
         if (tick && state != ST_IDLE)
            Overrun <= 1'b1;
         case (state)
            ST_IDLE:
               if (tick)
                  state <= ST_START;
            ST_START: begin
               tmo_cnt <= '0;
               state   <= ST_WAIT;
            end
            ST_WAIT:
               if (Adc_Done)
                  state <= ST_LOAD;
               else if (tmo_cnt == TMO_LAST)
                  state <= ST_ERR;
               else
                  tmo_cnt <= tmo_cnt + TMO_W'(1);
            ST_LOAD: begin
               Temp_Valid <= 1'b1;
               state      <= ST_IDLE;
            end
            ST_ERR: begin
               Timeout_Err <= 1'b1;
               Temp_Valid  <= 1'b0;
               state       <= ST_IDLE;
            end
            default:
               state <= ST_IDLE;
         endcase
      end
   end

   assign Adc_Start = (state == ST_START);
   assign Load_R    = (state == ST_LOAD);
   assign Busy      = (state == ST_START) || (state == ST_WAIT);

endmodule

// File: doc/sample_sequencer.md
SAMPLE_SEQUENCER -- requirements
Module: sample_sequencer

Interface
REQ-001 Parameter PERIOD_CYC, default 1000000, clock cycles between conversion starts; range 4..2^20.
REQ-002 Parameter TIMEOUT_CYC, default 1000, maximum cycles to wait for Adc_Done; range 2..2^16.
REQ-003 Clk_S  input  1  single clock; all state changes on rising edge.
REQ-004 Reset_S  input  1  asynchronous, active-high reset.
REQ-005 Run_S  input  1  level; 1 enables periodic sampling.
REQ-006 Clear_S  input  1  synchronous one-cycle pulse; clears sticky flags.
REQ-007 Adc_Done  input  1  converter completion strobe, sampled on Clk_S.
REQ-008 Adc_Start  output  1  one-cycle conversion request to converter.
REQ-009 Load_R  output  1  one-cycle load strobe to 8-bit temperature register.
REQ-010 Temp_Valid  output  1  1 = register holds a sample from a completed conversion.
REQ-011 Busy  output  1  1 while a conversion is in flight (states START, WAIT).
REQ-012 Timeout_Err  output  1  sticky; converter failed to answer within TIMEOUT_CYC.
REQ-013 Overrun  output  1  sticky; a period tick arrived while not IDLE.

Function
REQ-014 FSM states IDLE, START, WAIT, LOAD, ERR; all outputs decoded from registered state or registered flags, no combinational input-to-output path.
REQ-015 Period counter Per_Cnt (20 bit) increments each cycle while Run_S=1, wraps PERIOD_CYC-1 -> 0, held at 0 while Run_S=0.
REQ-016 IDLE -> START on edge where Run_S=1 and Per_Cnt=PERIOD_CYC-1; otherwise stay IDLE.
REQ-017 START lasts exactly one cycle with Adc_Start=1, then -> WAIT; timeout counter loaded with 0.
REQ-018 WAIT: Adc_Done=1 -> LOAD; else timeout counter = TIMEOUT_CYC-1 -> ERR; else counter +1.
REQ-019 Adc_Done and timeout in same cycle: Adc_Done wins (-> LOAD).
REQ-020 LOAD lasts one cycle with Load_R=1; Temp_Valid set to 1 on exit; -> IDLE.
REQ-021 Adc_Done-high edge to Load_R-high latency is exactly 1 cycle.
REQ-022 ERR lasts one cycle; Timeout_Err set, Temp_Valid cleared; -> IDLE; Load_R stays 0.
REQ-023 Adc_Done ignored in IDLE, START, LOAD, ERR.
REQ-024 Period tick (Per_Cnt=PERIOD_CYC-1, Run_S=1) while state not IDLE: tick dropped, Overrun set.
REQ-025 Run_S falling mid-conversion: current conversion completes via LOAD or ERR, then FSM stays IDLE.
REQ-026 Clear_S=1 clears Timeout_Err and Overrun; a set event in the same cycle wins over Clear_S.
REQ-027 Temp_Valid cleared only by ERR or reset, not by Run_S=0 or Clear_S.

Reset
REQ-028 Reset_S=1 forces immediately, independent of Clk_S: state IDLE, Per_Cnt 0, timeout counter 0, Adc_Start 0, Load_R 0, Temp_Valid 0, Busy 0, Timeout_Err 0, Overrun 0.
REQ-029 Reset asserted mid-conversion aborts it with no Load_R pulse; first Adc_Start after release no earlier than PERIOD_CYC cycles after release with Run_S=1.

Structure
REQ-030 Shared package holds FSM state encoding (3 bit) and default PERIOD_CYC / TIMEOUT_CYC constants.
REQ-031 One sub-module, tick_counter (parameterised modulo counter with enable and terminal-count output), implements Per_Cnt; timeout counter stays inline in FSM.
REQ-032 Load_R connects to the temperature register capture enable; sequencer holds no data path.

Verification (PERIOD_CYC=16, TIMEOUT_CYC=8)
REQ-033 Reset release, Run_S=1, Adc_Done returned 3 cycles after Adc_Start -> Adc_Start at cycle 16, Load_R one cycle after Adc_Done, Temp_Valid=1, Adc_Start again at cycle 32.
REQ-034 Adc_Done never asserted -> ERR after 8 WAIT cycles, Timeout_Err=1, Temp_Valid=0, no Load_R; Clear_S pulse -> Timeout_Err=0.
REQ-035 Adc_Done asserted on the 8th WAIT cycle (timeout coincident) -> LOAD, Timeout_Err stays 0.
REQ-036 TIMEOUT_CYC=20 override, no Adc_Done -> tick at cycle 32 during WAIT sets Overrun, no second Adc_Start until IDLE.
REQ-037 Run_S dropped during WAIT, Adc_Done 2 cycles later -> Load_R pulses once, Per_Cnt=0, no further Adc_Start.
REQ-038 Reset_S pulsed mid-WAIT between clock edges -> all outputs 0 immediately, late Adc_Done produces no Load_R.
